// File: rtl/ms_c2_pkg.sv
// rtl/ms_c2_pkg.sv - shared types and constants for the sign-magnitude to two's complement arbiter
package ms_c2_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int W_DEFAULT = 2;
  localparam int OW_CNT_W  = 8;

endpackage

// File: rtl/ms_c2_conv_core.sv
// rtl/ms_c2_conv_core.sv - combinational sign-magnitude to W-bit two's complement conversion
module ms_c2_conv_core #(
  parameter int W = 2
) (
  input  logic [W-1:0] abs_i,
  input  logic         sgn_i,
  output logic [W-1:0] z_o,
  output logic         ow_o
);

  localparam logic [W-1:0] MIN_MAG = {1'b1, {(W-1){1'b0}}};

  // Negating zero wraps back to zero, so negative zero needs no special case.
  assign z_o  = sgn_i ? (~abs_i + 1'b1) : abs_i;
  assign ow_o = abs_i[W-1] && !(sgn_i && (abs_i == MIN_MAG));

endmodule

// File: rtl/ms_c2_conv_arbiter.sv
// rtl/ms_c2_conv_arbiter.sv - two-requester round-robin arbiter feeding a one-slot conversion register
// Optional saturating overflow counter port ow_count enabled by MS_C2_OW_COUNT_EN.
module ms_c2_conv_arbiter
  import ms_c2_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in0_valid,
  input  logic [W-1:0] in0_abs,
  input  logic         in0_sgn,
  output logic         in0_ready,
  input  logic         in1_valid,
  input  logic [W-1:0] in1_abs,
  input  logic         in1_sgn,
  output logic         in1_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_z,
  output logic         out_ow,
  output logic         out_id
`ifdef MS_C2_OW_COUNT_EN
  ,
  output logic [OW_CNT_W-1:0] ow_count
`endif
);

  state_e       state_q, state_d;
  logic         rp_q, rp_d;
  logic [W-1:0] z_q, z_d;
  logic         ow_q, ow_d;
  logic         id_q, id_d;

  logic         both_v, any_v, gnt_id, slot_free, accept;
  logic [W-1:0] sel_abs, conv_z;
  logic         sel_sgn, conv_ow;

  always_comb begin
    both_v    = in0_valid & in1_valid;
    any_v     = in0_valid | in1_valid;
    gnt_id    = both_v ? rp_q : in1_valid;
    // Reset blocks acceptance so a held result is dropped without a handshake.
    slot_free = !reset && ((state_q == ST_EMPTY) || out_ready);
    accept    = slot_free & any_v;
    in0_ready = accept & ~gnt_id;
    in1_ready = accept & gnt_id;
    sel_abs   = gnt_id ? in1_abs : in0_abs;
    sel_sgn   = gnt_id ? in1_sgn : in0_sgn;
  end

  ms_c2_conv_core #(.W(W)) u_conv (
    .abs_i (sel_abs),
    .sgn_i (sel_sgn),
    .z_o   (conv_z),
    .ow_o  (conv_ow)
  );

  always_comb begin
    state_d = state_q;
    rp_d    = rp_q;
    z_d     = z_q;
    ow_d    = ow_q;
    id_d    = id_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (accept) begin
      z_d  = conv_z;
      ow_d = conv_ow;
      id_d = gnt_id;
      if (both_v) rp_d = ~gnt_id;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      rp_q    <= 1'b0;
      z_q     <= '0;
      ow_q    <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rp_q    <= rp_d;
      z_q     <= z_d;
      ow_q    <= ow_d;
      id_q    <= id_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_z     = z_q;
  assign out_ow    = ow_q;
  assign out_id    = id_q;

`ifdef MS_C2_OW_COUNT_EN
  logic [OW_CNT_W-1:0] ow_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      ow_cnt_q <= '0;
    end else if (accept && conv_ow && (ow_cnt_q != '1)) begin
      ow_cnt_q <= ow_cnt_q + 1'b1;
    end
  end

  assign ow_count = ow_cnt_q;
`endif

endmodule

// File: tb/tb_ms_c2_conv_arbiter.sv
// tb/tb_ms_c2_conv_arbiter.sv - directed vector bench for ms_c2_conv_arbiter (W=2)
module tb_ms_c2_conv_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       in0_valid, in0_sgn, in0_ready;
  logic [1:0] in0_abs;
  logic       in1_valid, in1_sgn, in1_ready;
  logic [1:0] in1_abs;
  logic       out_valid, out_ready, out_ow, out_id;
  logic [1:0] out_z;
`ifdef MS_C2_OW_COUNT_EN
  logic [7:0] ow_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ms_c2_conv_arbiter #(.W(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .in0_valid (in0_valid),
    .in0_abs   (in0_abs),
    .in0_sgn   (in0_sgn),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_abs   (in1_abs),
    .in1_sgn   (in1_sgn),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_ow    (out_ow),
    .out_id    (out_id)
`ifdef MS_C2_OW_COUNT_EN
    ,
    .ow_count  (ow_count)
`endif
  );

  typedef struct {
    logic       v0;
    logic [1:0] a0;
    logic       s0;
    logic       v1;
    logic [1:0] a1;
    logic       s1;
    logic       ordy;
    logic       er0;
    logic       er1;
    logic       eov;
    logic [1:0] ez;
    logic       eow;
    logic       eid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v0, logic [1:0] a0, logic s0,
                              logic v1, logic [1:0] a1, logic s1, logic ordy,
                              logic er0, logic er1, logic eov,
                              logic [1:0] ez, logic eow, logic eid);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.s0 = s0;
    v.v1 = v1; v.a1 = a1; v.s1 = s1; v.ordy = ordy;
    v.er0 = er0; v.er1 = er1; v.eov = eov;
    v.ez = ez; v.eow = eow; v.eid = eid;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(logic v0, logic [1:0] a0, logic s0,
                       logic v1, logic [1:0] a1, logic s1, logic ordy);
    in0_valid = v0; in0_abs = a0; in0_sgn = s0;
    in1_valid = v1; in1_abs = a1; in1_sgn = s1;
    out_ready = ordy;
  endtask

  task automatic apply(vec_t v, int idx);
    drive(v.v0, v.a0, v.s0, v.v1, v.a1, v.s1, v.ordy);
    #2;
    check($sformatf("v%0d in0_ready", idx), in0_ready, v.er0);
    check($sformatf("v%0d in1_ready", idx), in1_ready, v.er1);
    tick();
    check($sformatf("v%0d out_valid", idx), out_valid, v.eov);
    if (v.eov) begin
      check($sformatf("v%0d out_z", idx), out_z, v.ez);
      check($sformatf("v%0d out_ow", idx), out_ow, v.eow);
      check($sformatf("v%0d out_id", idx), out_id, v.eid);
    end
  endtask

  initial begin
    //            v0 a0    s0 v1 a1    s1 ordy r0 r1 ov z     ow id
    vecs.push_back(mk(1, 2'b01, 1, 0, 2'b00, 0, 1,  1, 0, 1, 2'b11, 0, 0));
    vecs.push_back(mk(1, 2'b10, 0, 1, 2'b10, 1, 1,  1, 0, 1, 2'b10, 1, 0));
    vecs.push_back(mk(1, 2'b00, 1, 1, 2'b10, 1, 1,  0, 1, 1, 2'b10, 0, 1));
    vecs.push_back(mk(1, 2'b11, 0, 1, 2'b01, 0, 1,  1, 0, 1, 2'b11, 1, 0));
    vecs.push_back(mk(1, 2'b00, 1, 0, 2'b11, 1, 1,  1, 0, 1, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b11, 1, 0, 2'b11, 1, 1,  0, 0, 0, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b01, 0, 1, 2'b11, 1, 1,  0, 1, 1, 2'b01, 1, 1));
    vecs.push_back(mk(0, 2'b00, 0, 1, 2'b01, 0, 0,  0, 0, 1, 2'b01, 1, 1));
    vecs.push_back(mk(0, 2'b00, 0, 1, 2'b01, 0, 0,  0, 0, 1, 2'b01, 1, 1));
    vecs.push_back(mk(0, 2'b00, 0, 1, 2'b01, 0, 0,  0, 0, 1, 2'b01, 1, 1));
    vecs.push_back(mk(0, 2'b00, 0, 1, 2'b01, 0, 1,  0, 1, 1, 2'b01, 0, 1));
    vecs.push_back(mk(0, 2'b00, 0, 0, 2'b00, 0, 0,  0, 0, 1, 2'b01, 0, 1));
    vecs.push_back(mk(0, 2'b00, 0, 0, 2'b00, 0, 1,  0, 0, 0, 2'b00, 0, 0));
    // Full conversion sweep through requester 0
    vecs.push_back(mk(1, 2'b00, 0, 0, 2'b00, 0, 1,  1, 0, 1, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b00, 1, 0, 2'b00, 0, 1,  1, 0, 1, 2'b00, 0, 0));
    vecs.push_back(mk(1, 2'b01, 0, 0, 2'b00, 0, 1,  1, 0, 1, 2'b01, 0, 0));
    vecs.push_back(mk(1, 2'b01, 1, 0, 2'b00, 0, 1,  1, 0, 1, 2'b11, 0, 0));
    vecs.push_back(mk(1, 2'b10, 0, 0, 2'b00, 0, 1,  1, 0, 1, 2'b10, 1, 0));
    vecs.push_back(mk(1, 2'b10, 1, 0, 2'b00, 0, 1,  1, 0, 1, 2'b10, 0, 0));
    vecs.push_back(mk(1, 2'b11, 0, 0, 2'b00, 0, 1,  1, 0, 1, 2'b11, 1, 0));
    vecs.push_back(mk(1, 2'b11, 1, 0, 2'b00, 0, 1,  1, 0, 1, 2'b01, 1, 0));

    reset = 1'b1;
    drive(1, 2'b01, 0, 1, 2'b01, 0, 1);
    #2;
    check("reset in0_ready", in0_ready, 1'b0);
    check("reset in1_ready", in1_ready, 1'b0);
    tick();
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_z", out_z, 2'b00);
    check("reset out_ow", out_ow, 1'b0);
    check("reset out_id", out_id, 1'b0);
`ifdef MS_C2_OW_COUNT_EN
    check("reset ow_count", ow_count, 8'd0);
`endif
    reset = 1'b0;

    foreach (vecs[i]) apply(vecs[i], i);

    // Round-robin alternation with both requesters held valid
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'b01, 0, 1, 2'b10, 1, 1);
      #2;
      check($sformatf("rr%0d in0_ready", i), in0_ready, (i % 2) == 0);
      check($sformatf("rr%0d in1_ready", i), in1_ready, (i % 2) == 1);
      tick();
      check($sformatf("rr%0d out_id", i), out_id, (i % 2) == 1);
      check($sformatf("rr%0d out_z", i), out_z, ((i % 2) == 1) ? 2'b10 : 2'b01);
    end

    // Leave rp pointing at requester 1 and the slot full, then reset
    apply(mk(1, 2'b01, 0, 1, 2'b01, 0, 1, 1, 0, 1, 2'b01, 0, 0), 100);
    reset = 1'b1;
    drive(1, 2'b11, 0, 1, 2'b11, 0, 0);
    #2;
    check("rstfull in0_ready", in0_ready, 1'b0);
    check("rstfull in1_ready", in1_ready, 1'b0);
    tick();
    check("rstfull out_valid", out_valid, 1'b0);
    check("rstfull out_z", out_z, 2'b00);
    reset = 1'b0;
    apply(mk(1, 2'b01, 0, 1, 2'b10, 0, 1, 1, 0, 1, 2'b01, 0, 0), 101);

`ifdef MS_C2_OW_COUNT_EN
    drive(1, 2'b11, 0, 0, 2'b00, 0, 1);
    for (int i = 0; i < 300; i++) tick();
    check("ow_count saturate", ow_count, 8'd255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
